// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: command and result signals between the ALU decoder and the shift sequencer
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             ovf;
  modport master (output start, mode, amount, x, input busy, done, f, cout, ovf);
  modport slave (input start, mode, amount, x, output busy, done, f, cout, ovf);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 1-bit-per-clock left shifter with LSL/ROL/ASL modes and sticky overflow
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic               clk,
  input logic               rst,
  shift_sequencer_if.slave  bus
);
  localparam logic [1:0] ROL = 2'b01;
  localparam logic [1:0] ASL = 2'b10;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, state_nx;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] f_q;
  logic             cout_q, ovf_q;
  logic             accept, msb, ovf_step;
  logic [WIDTH-1:0] f_nx;
  assign accept = state == IDLE && bus.start;
  assign msb = f_q[WIDTH-1];
  assign f_nx = {f_q[WIDTH-2:0], mode_q == ROL ? msb : 1'b0};
  assign ovf_step = mode_q == ASL && (f_q[WIDTH-1] ^ f_q[WIDTH-2]);
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: a zero amount skips SHIFT; the last step (cnt<=1) completes
  always_comb
    state_nx = state == IDLE  ? (bus.start ? (bus.amount != '0 ? SHIFT : DONE) : IDLE) :
               state == SHIFT ? (cnt <= AMT_W'(1) ? DONE : SHIFT) :
               IDLE;
  // outputs decoded from state
  always_comb begin
    bus.busy = state == SHIFT;
    bus.done = state == DONE;
  end
  // datapath: load on accepted start, one step per SHIFT cycle, hold otherwise
  always_ff @(posedge clk)
    if (rst) begin
      f_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt <= '0;
      mode_q <= 2'b00;
    end else if (accept) begin
      f_q <= bus.x;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt <= bus.amount;
      mode_q <= bus.mode;
    end else if (state == SHIFT) begin
      f_q <= f_nx;
      cout_q <= msb;
      ovf_q <= ovf_q | ovf_step;
      cnt <= cnt != '0 ? cnt - 1'b1 : cnt;
    end
  assign bus.f = f_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
endmodule
